// File: rtl/prefetch_fifo.sv
// Prefetch FIFO: pulls words from an upstream show-ahead source into a D-entry buffer
// and presents the oldest word on a registered show-ahead output.
module prefetch_fifo #(
  parameter  int W = 8,
  parameter  int D = 4,
  localparam int A = $clog2(D)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic [W-1:0] in,
  output logic         get_i,
  input  logic         empty_i,
  output logic [W-1:0] out,
  input  logic         get_o,
  output logic         empty_o,
  output logic [A:0]   count,
  output logic         full
);

  localparam logic [A:0] CNT_ONE  = (A+1)'(1);
  localparam logic [A:0] CNT_FULL = (A+1)'(D);

  logic [W-1:0] mem_q [D];
  logic [A-1:0] wptr_q, rptr_q, rptr_nxt;
  logic [A:0]   count_q, count_d;
  logic         empty_q, full_q;
  logic [W-1:0] out_q, out_d;
  logic         push, pop;

  assign pop      = get_o & ~empty_q;
  assign get_i    = ~empty_i & ~reset & ~flush & (~full_q | pop);
  assign push     = get_i;
  assign rptr_nxt = rptr_q + 1'b1;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // The head register is reloaded from the array, or straight from upstream when the
  // buffer is (or is about to become) otherwise empty.
  always_comb begin
    out_d = out_q;
    if (push && empty_q) begin
      out_d = in;
    end else if (pop) begin
      if (count_q > CNT_ONE) begin
        out_d = mem_q[rptr_nxt];
      end else if (push) begin
        out_d = in;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_nxt;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_FULL);
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= in;
  end

  assign out     = out_q;
  assign empty_o = empty_q;
  assign count   = count_q;
  assign full    = full_q;

endmodule

// File: tb/tb_prefetch_fifo.sv
// Scoreboard bench for prefetch_fifo: driver models acceptance and occupancy,
// a separate negedge monitor checks every delivered word against the expected queue.
module tb_prefetch_fifo;
  localparam int W = 8;
  localparam int D = 4;
  localparam int A = $clog2(D);

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic [W-1:0] in = '0;
  logic         get_i;
  logic         empty_i = 1'b1;
  logic [W-1:0] out;
  logic         get_o = 1'b0;
  logic         empty_o;
  logic [A:0]   count;
  logic         full;

  prefetch_fifo #(.W(W), .D(D)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in(in), .get_i(get_i),
    .empty_i(empty_i), .out(out), .get_o(get_o), .empty_o(empty_o),
    .count(count), .full(full)
  );

  always #5 clock = ~clock;

  int           tests = 0;
  int           fails = 0;
  int           mdl_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] nxt_w;
  bit           done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at posedge+2, check get_i at +4, check status after the next edge.
  task automatic drive(input logic r, input logic f, input logic ei, input logic go,
                       input logic [W-1:0] w, output logic acc);
    logic egi;
    int   popm;
    #1;
    reset = r; flush = f; empty_i = ei; get_o = go; in = w;
    #2;
    egi = !ei && !r && !f && (mdl_cnt < D || (go && mdl_cnt > 0));
    check("get_i", get_i, egi);
    popm = (go && mdl_cnt > 0) ? 1 : 0;
    if (r || f) begin
      exp_q.delete();
      mdl_cnt = 0;
    end else begin
      if (egi) exp_q.push_back(w);
      mdl_cnt = mdl_cnt + (egi ? 1 : 0) - popm;
    end
    acc = egi;
    @(posedge clock);
    #1;
    check("count", count, mdl_cnt);
    check("empty_o", empty_o, mdl_cnt == 0);
    check("full", full, mdl_cnt == D);
  endtask

  task automatic run(input logic r, input logic f, input logic ei, input logic go,
                     input int n, input logic [W-1:0] step);
    logic acc;
    for (int i = 0; i < n; i++) begin
      drive(r, f, ei, go, nxt_w, acc);
      if (acc) nxt_w = nxt_w + step;
    end
  endtask

  // Monitor: whenever the DUT shows a word it must be the scoreboard head; a pop retires it.
  initial begin
    while (!done) begin
      @(negedge clock);
      if (!reset && !flush && empty_o === 1'b0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL out_unexpected: got %0h expected no word at %0t", out, $time);
        end else begin
          check("out", out, exp_q[0]);
          if (get_o) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic acc;
    nxt_w = '0;
    run(1, 0, 1, 0, 2, 8'h01);

    // Fill: 0x11..0x44 taken, 0x55 held off by full
    nxt_w = 8'h11;
    run(0, 0, 0, 0, 6, 8'h11);
    check("fill_out", out, 8'h11);
    check("fill_full", full, 1);
    check("fill_stall", nxt_w, 8'h55);

    // Drain with one extra pop while empty
    run(0, 0, 1, 1, 5, 8'h01);
    check("drain_empty", empty_o, 1);

    // Streaming
    nxt_w = 8'h00;
    run(0, 0, 0, 1, 17, 8'h01);
    check("stream_cnt", count, 1);
    run(0, 0, 1, 1, 2, 8'h01);

    // Full pass-through across pointer wrap
    run(0, 0, 0, 0, 4, 8'h01);
    run(0, 0, 0, 1, 12, 8'h01);
    check("pass_cnt", count, 4);
    run(0, 0, 1, 1, 5, 8'h01);

    // Flush at count 3, then refill
    run(0, 0, 0, 0, 3, 8'h01);
    run(0, 0, 1, 0, 1, 8'h01);
    run(0, 1, 0, 0, 1, 8'h01);
    check("flush_cnt", count, 0);
    run(0, 0, 0, 1, 6, 8'h01);
    run(0, 0, 1, 1, 3, 8'h01);

    // Reset mid-stream at count 2
    run(0, 0, 0, 0, 2, 8'h01);
    run(1, 0, 0, 1, 1, 8'h01);
    check("rst_empty", empty_o, 1);
    run(0, 0, 1, 0, 1, 8'h01);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
            W'($urandom), acc);
    end

    run(0, 0, 1, 1, D + 2, 8'h01);
    check("sb_drained", exp_q.size(), 0);
    done = 1;
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
